ccg_vector_sweeper: RTL and testbench
=====================================

// Module: ccg_vector_sweeper
// PURPOSE
//  Sequencer that drives a combinational CCG benchmark netlist (20 inputs x0..x19, 28 outputs f1..f28).
//  Generates input vectors exhaustively or pseudo-randomly, holds each vector for a settle window and samples the outputs.
//  Compacts the outputs into a 32-bit MISR signature and counts vectors where f1 and f8 are high.
//  Sits between the host and the netlist for characterization and golden-signature checks.
// PARAMETERS
//  N_IN       20          netlist input width (dut_x)
//  N_OUT      28          netlist output width (dut_f; bit k-1 = f<k>)
//  SETTLE_CYC 2           cycles dut_x is held before capture; legal range 1..15
//  LFSR_POLY  20'h90000   Galois mask for LFSR mode (x^20+x^17+1)
//  MISR_POLY  32'h04C11DB7 MISR feedback mask
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  start        in   1        begin sweep (sampled in IDLE only)
//  abort        in   1        cancel sweep in progress
//  mode         in   1        0 = binary counter from 0; 1 = LFSR from seed
//  seed         in   N_IN     LFSR seed, latched at start; 0 is coerced to 1
//  num_vectors  in   N_IN+1   vectors to apply, latched at start (2^20 = full exhaustive)
//  dut_x        out  N_IN     vector to netlist
//  dut_f        in   N_OUT    netlist outputs
//  busy         out  1        sweep in progress
//  done         out  1        one-cycle pulse at completion (not on abort)
//  signature    out  32       MISR value
//  f1_hits      out  N_IN+1   count of captured vectors with dut_f[0]=1
//  f8_hits      out  N_IN+1   count of captured vectors with dut_f[7]=1
// BEHAVIOUR
//  Reset: state IDLE; dut_x, signature, f1_hits, f8_hits = 0; busy = done = 0.
//  FSM: IDLE -> APPLY -> CAPTURE -> (APPLY | DONE) -> IDLE.
//  IDLE: start=1 & abort=0 -> latch mode, seed, num_vectors; clear signature and hit counters.
//    If num_vectors != 0, go to APPLY with dut_x = 0 (mode 0) or seed (mode 1).
//    If num_vectors == 0, go to DONE; signature stays 0.
//  APPLY: dut_x is held stable for exactly SETTLE_CYC cycles; busy = 1.
//  CAPTURE (1 cycle, busy = 1):
//    sig <= {sig[30:0],1'b0} ^ (sig[31] ? MISR_POLY : 0) ^ {4'b0, dut_f}.
//    Hit counters increment per dut_f[0] / dut_f[7].
//    Vector advances: mode 0 increments mod 2^N_IN; mode 1 next = (v>>1) ^ (v[0] ? LFSR_POLY : 0).
//    remaining decrements. If remaining was 1, go to DONE; else go to APPLY.
//  DONE: done = 1 and busy = 0 for one cycle, then IDLE. Results hold until the next start.
//  Latency: start sampled in cycle T -> done high in cycle T+1+N*(SETTLE_CYC+1).
//  start while not IDLE: ignored.
//  abort in APPLY or CAPTURE: IDLE next cycle, no done pulse, partial results held.
//    An abort in CAPTURE still performs that capture's update.
//  abort in IDLE or DONE: no effect. Simultaneous start and abort in IDLE: abort wins.
//  dut_x is unchanged when entering IDLE (last vector held).
//  rst_n low mid-sweep: immediate return to reset values. No resume.
//  Hit counters do not saturate; max value 2^20 fits in N_IN+1 bits.
// STRUCTURE
//  Package ccg_sweep_pkg holds:
//    state enum {IDLE, APPLY, CAPTURE, DONE};
//    CCG_N_IN / CCG_N_OUT constants;
//    default LFSR_POLY / MISR_POLY constants.
//  Sub-module ccg_misr32 (clk, rst_n, clr, en, din[31:0], sig[31:0]) holds the signature register.
//  Vector generator, settle counter and FSM stay in the top module.
// TESTING
//  1. mode=0, N=4, SETTLE=2, dut_f tied to {8'b0, dut_x}:
//     dut_x steps 0,1,2,3 at 3-cycle spacing; done exactly 13 cycles after start; f1_hits=2.
//  2. mode=1, seed=0, N=3: dut_x = 1, 0x90000, 0x48000; dut_f=0 -> signature stays 0, f1_hits=f8_hits=0.
//  3. dut_f=28'h0000001 constant, N=2: signature = 32'h00000003.
//  4. N=0: done pulses the cycle after start; busy never rises; signature=0.
//  5. abort in 2nd APPLY of N=5:
//     busy drops next cycle, no done, f1_hits reflects exactly 1 capture; start during busy ignored.
//  6. rst_n low mid-CAPTURE: all outputs 0 asynchronously.
//     A new start after release reproduces the test-1 result bit-exactly.

Source files
------------

// File: rtl/ccg_sweep_pkg.sv
// Shared types and constants for the CCG benchmark vector sweeper.
package ccg_sweep_pkg;

    localparam int unsigned CCG_N_IN  = 20;
    localparam int unsigned CCG_N_OUT = 28;
    localparam int unsigned CNT_W     = 4;

    localparam logic [CCG_N_IN-1:0] CCG_LFSR_POLY = 20'h90000;
    localparam logic [31:0]         CCG_MISR_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/ccg_misr32.sv
// 32-bit multiple-input signature register compacting netlist responses.
module ccg_misr32
    import ccg_sweep_pkg::*;
#(
    parameter logic [31:0] POLY = CCG_MISR_POLY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] sig
);

    logic [31:0] sig_q, sig_d;

    // Clear has priority so a new sweep always starts from a zero signature.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/ccg_vector_sweeper.sv
// Drives the CCG netlist with counter/LFSR vectors, holds each for a settle
// window, then folds the sampled outputs into a MISR and hit counters.
module ccg_vector_sweeper
    import ccg_sweep_pkg::*;
#(
    parameter int unsigned     N_IN       = CCG_N_IN,
    parameter int unsigned     N_OUT      = CCG_N_OUT,
    parameter int unsigned     SETTLE_CYC = 2,
    parameter logic [N_IN-1:0] LFSR_POLY  = CCG_LFSR_POLY,
    parameter logic [31:0]     MISR_POLY  = CCG_MISR_POLY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [N_IN-1:0]  seed,
    input  logic [N_IN:0]    num_vectors,
    output logic [N_IN-1:0]  dut_x,
    input  logic [N_OUT-1:0] dut_f,
    output logic             busy,
    output logic             done,
    output logic [31:0]      signature,
    output logic [N_IN:0]    f1_hits,
    output logic [N_IN:0]    f8_hits
);

    localparam int unsigned     HIT_W    = N_IN + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [HIT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [HIT_W-1:0]   f1_q, f1_d;
    logic [HIT_W-1:0]   f8_q, f8_d;
    logic               misr_clr_c;
    logic               misr_en_c;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        f1_d       = f1_q;
        f8_d       = f8_q;
        misr_clr_c = 1'b0;
        misr_en_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mode_d     = mode;
                    rem_d      = num_vectors;
                    cnt_d      = '0;
                    f1_d       = '0;
                    f8_d       = '0;
                    misr_clr_c = 1'b1;
                    if (num_vectors != '0) begin
                        state_d = APPLY;
                        vec_d   = mode ? ((seed == '0) ? VEC_ONE : seed) : '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            APPLY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Capture completes even when aborted in the same cycle.
            CAPTURE: begin
                misr_en_c = 1'b1;
                f1_d      = f1_q + HIT_W'(dut_f[0]);
                f8_d      = f8_q + HIT_W'(dut_f[7]);
                vec_d     = mode_q ? ((vec_q >> 1) ^ (vec_q[0] ? LFSR_POLY : '0))
                                   : vec_q + VEC_ONE;
                rem_d     = rem_q - HIT_W'(1);
                cnt_d     = '0;
                if (abort) begin
                    state_d = IDLE;
                end else if (rem_q == HIT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == APPLY) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            f1_q    <= '0;
            f8_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            f1_q    <= f1_d;
            f8_q    <= f8_d;
        end
    end

    ccg_misr32 #(
        .POLY (MISR_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr_c),
        .en    (misr_en_c),
        .din   (32'(dut_f)),
        .sig   (signature)
    );

    assign dut_x   = vec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign f1_hits = f1_q;
    assign f8_hits = f8_q;

endmodule

// File: tb/tb_ccg_vector_sweeper.sv
// Scoreboard bench for ccg_vector_sweeper with a behavioural netlist stand-in.
module tb_ccg_vector_sweeper;

    localparam int S = 2;

    typedef struct {
        int          cyc;
        logic [19:0] val;
    } vexp_t;

    typedef struct {
        int          cyc;
        logic [31:0] sig;
        logic [20:0] f1;
        logic [20:0] f8;
    } rexp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        mode;
    logic [19:0] seed;
    logic [20:0] num_vectors;
    logic [19:0] dut_x;
    logic [27:0] dut_f;
    logic        busy;
    logic        done;
    logic [31:0] signature;
    logic [20:0] f1_hits;
    logic [20:0] f8_hits;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int net_sel = 0;

    vexp_t vq[$];
    rexp_t rq[$];

    logic [31:0] last_sig;
    logic [20:0] last_f1;
    logic [20:0] last_f8;

    ccg_vector_sweeper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .seed        (seed),
        .num_vectors (num_vectors),
        .dut_x       (dut_x),
        .dut_f       (dut_f),
        .busy        (busy),
        .done        (done),
        .signature   (signature),
        .f1_hits     (f1_hits),
        .f8_hits     (f8_hits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Netlist stand-in: selectable response functions of the applied vector.
    function automatic logic [27:0] netf(input int sel, input logic [19:0] x);
        logic [31:0] t;
        case (sel)
            0: return {8'b0, x};
            1: return 28'h0000001;
            2: return 28'h0;
            default: begin
                t = {12'b0, x} * 32'h9E3779B1;
                return t[27:0] ^ {x[7:0], x};
            end
        endcase
    endfunction

    assign dut_f = netf(net_sel, dut_x);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares held vectors and done-pulse results against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vq.size() > 0 && vq[0].cyc == cyc) begin
                vexp_t e;
                e = vq.pop_front();
                chk("dut_x", 64'(dut_x), 64'(e.val));
                chk("busy_during_sweep", 64'(busy), 64'd1);
            end
            if (done) begin
                if (rq.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(r.cyc));
                    chk("busy_at_done", 64'(busy), 64'd0);
                    chk("signature", 64'(signature), 64'(r.sig));
                    chk("f1_hits", 64'(f1_hits), 64'(r.f1));
                    chk("f8_hits", 64'(f8_hits), 64'(r.f8));
                end
            end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
                rq.delete(0);
                chk("done_missing", 64'd0, 64'd1);
            end
        end
    end

    // One sweep: build the expected vectors/results, start it, optionally abort at offset abort_o.
    task automatic run_sweep(input bit m, input logic [19:0] sd, input int n,
                             input int ns, input int abort_o);
        int          k, caps, limit, stop;
        logic [19:0] v;
        logic [27:0] f;
        logic [31:0] sig;
        logic [20:0] h1, h8;
        bit          poke;

        k     = cyc;
        caps  = (abort_o >= 0) ? abort_o / (S + 1) : n;
        limit = (abort_o >= 0) ? abort_o : 1 << 30;
        v     = m ? ((sd == 20'h0) ? 20'h1 : sd) : 20'h0;
        sig   = 32'h0;
        h1    = 21'h0;
        h8    = 21'h0;
        for (int j = 0; j < n; j++) begin
            if (1 + j * (S + 1) <= limit) vq.push_back('{k + 1 + j * (S + 1), v});
            if ((j + 1) * (S + 1) <= limit) vq.push_back('{k + (j + 1) * (S + 1), v});
            if (j < caps) begin
                f   = netf(ns, v);
                sig = (sig << 1) ^ (sig[31] ? 32'h04C11DB7 : 32'h0) ^ {4'b0, f};
                h1  = h1 + 21'(f[0]);
                h8  = h8 + 21'(f[7]);
            end
            v = m ? ((v >> 1) ^ (v[0] ? 20'h90000 : 20'h0)) : v + 20'h1;
        end
        if (abort_o < 0) rq.push_back('{k + 1 + n * (S + 1), sig, h1, h8});
        last_sig = sig;
        last_f1  = h1;
        last_f8  = h8;

        net_sel     = ns;
        mode        = m;
        seed        = sd;
        num_vectors = 21'(n);
        start       = 1'b1;
        @(negedge clk);
        stop = (abort_o >= 0) ? abort_o + 1 : n * (S + 1) + 2;
        poke = (n > 0) && (abort_o < 0 || abort_o >= 2);
        while (cyc < k + stop) begin
            if (poke && cyc == k + 2) begin
                start       = 1'b1;
                mode        = ~m;
                seed        = 20'($urandom);
                num_vectors = 21'd7;
            end else begin
                start = 1'b0;
            end
            abort = (abort_o >= 0 && cyc == k + abort_o);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_after", 64'(done), 64'd0);
        if (abort_o >= 0) begin
            chk("abort_signature", 64'(signature), 64'(sig));
            chk("abort_f1_hits", 64'(f1_hits), 64'(h1));
            chk("abort_f8_hits", 64'(f8_hits), 64'(h8));
            repeat (4) @(negedge clk);
            vq.delete();
        end else begin
            chk("done_seen", 64'(rq.size()), 64'd0);
        end
    endtask

    initial begin
        int k;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        mode        = 1'b0;
        seed        = 20'h0;
        num_vectors = 21'h0;
        repeat (2) @(negedge clk);
        chk("rst_dut_x", 64'(dut_x), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_signature", 64'(signature), 64'd0);
        chk("rst_f1_hits", 64'(f1_hits), 64'd0);
        chk("rst_f8_hits", 64'(f8_hits), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(1'b0, 20'h0, 4, 0, -1);
        chk("t1_f1_hits_is_2", 64'(last_f1), 64'd2);
        run_sweep(1'b1, 20'h0, 3, 2, -1);
        run_sweep(1'b0, 20'h0, 2, 1, -1);
        chk("t3_sig_is_3", 64'(signature), 64'h3);
        run_sweep(1'b0, 20'h0, 0, 3, -1);
        run_sweep(1'b0, 20'h0, 5, 3, 4);
        run_sweep(1'b1, 20'h5A5A5, 5, 3, 9);

        // start+abort together in IDLE, and abort alone: no effect.
        k = cyc;
        start = 1'b1;
        abort = 1'b1;
        num_vectors = 21'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 64'(busy), 64'd0);
        chk("idle_abort_sig_held", 64'(signature), 64'(last_sig));
        chk("idle_abort_f1_held", 64'(f1_hits), 64'(last_f1));

        // Reset asserted during the third capture of a test-1 sweep.
        net_sel     = 0;
        mode        = 1'b0;
        num_vectors = 21'd4;
        k = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 9) @(negedge clk);
        chk("pre_rst_sig_nonzero", 64'(signature != 32'h0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dut_x", 64'(dut_x), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_signature", 64'(signature), 64'd0);
        chk("mid_rst_f1_hits", 64'(f1_hits), 64'd0);
        chk("mid_rst_f8_hits", 64'(f8_hits), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        run_sweep(1'b0, 20'h0, 4, 0, -1);

        for (int i = 0; i < 8; i++) begin
            logic [19:0] sd;
            sd = (i == 3) ? 20'h0 : 20'($urandom);
            run_sweep(1'($urandom), sd, int'($urandom_range(1, 6)), 3, -1);
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(vq.size() + rq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
